pipe_stage_buf: RTL

//  Generic parametrised inter-stage pipeline register; the next-generation replacement for the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.

---
 rtl/pipe_stage_buf.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// optional 2-entry skid buffer, flush-to-bubble and saturating perf counters.
module pipe_stage_buf #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 19,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_q, bubble_q;

  logic head_v;
  logic acc;
  logic rel;

  assign head_v = (state_q != EMPTY);
  assign acc    = in_valid & in_ready;
  assign rel    = head_v & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;
      // Registered ready: TWO is the only state that refuses input.
      always_ff @(posedge CLK) begin
        if (RST) rdy_q <= 1'b1;
        else     rdy_q <= (state_d != TWO);
      end
      assign in_ready = ~RST & rdy_q;
    end else begin : g_noskid
      assign in_ready = ~RST & (~head_v | out_ready);
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d     = ONE;
          head_data_d = in_data;
          head_ctrl_d = in_ctrl;
        end
      end
      ONE: begin
        if (acc && rel) begin
          head_data_d = in_data;
          head_ctrl_d = in_ctrl;
        end else if (acc) begin
          state_d     = TWO;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end else if (rel) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (rel) begin
          state_d     = ONE;
          head_data_d = skid_data_q;
          head_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash everything; any same-cycle accept is dropped.
    if (flush) begin
      state_d     = EMPTY;
      head_ctrl_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_ctrl_q <= head_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (in_valid && !in_ready && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
      if (out_ready && !head_v && bubble_q != '1)
        bubble_q <= bubble_q + CNT_W'(1);
    end
  end

  assign out_valid  = head_v;
  assign out_data   = head_data_q;
  assign out_ctrl   = head_v ? head_ctrl_q : '0;
  assign occupancy  = state_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule
